// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester round-robin data-memory arbiter with capped burst lock
// Requester 0 is the core path, requester 1 the loader/DMA/debug path.
module dmem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic          r0_lock,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic          r1_lock,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_owner;
  logic          w_owner_nxt;
  logic          r_last;
  logic          w_last_nxt;
  logic [CW-1:0] r_burst_cnt;
  logic [CW-1:0] w_burst_cnt_nxt;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic          w_owner_req;
  logic          w_hold;
  logic          w_gnt_any;
  logic          w_gnt_id;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_we;
  logic          w_lock;

  // The lock only holds while the owner keeps requesting and has beats left;
  // otherwise plain round-robin decides in the same cycle.
  always_comb begin
    w_owner_req = r_owner ? r1_req : r0_req;
    w_hold      = (r_state == S_LOCKED) && w_owner_req && (r_burst_cnt < CW'(MAX_BURST));
    w_gnt_any   = 1'b0;
    w_gnt_id    = 1'b0;
    if (!reset) begin
      if (w_hold) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = r_owner;
      end else if (r0_req && r1_req) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = ~r_last;
      end else if (r0_req) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = 1'b0;
      end else if (r1_req) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = 1'b1;
      end
    end
  end

  assign w_gnt0 = w_gnt_any & ~w_gnt_id;
  assign w_gnt1 = w_gnt_any &  w_gnt_id;
  assign w_we   = w_gnt_id ? r1_we   : r0_we;
  assign w_lock = w_gnt_id ? r1_lock : r0_lock;

  always_comb begin
    w_state_nxt     = S_IDLE;
    w_owner_nxt     = r_owner;
    w_last_nxt      = r_last;
    w_burst_cnt_nxt = '0;
    if (w_gnt_any) begin
      w_last_nxt = w_gnt_id;
      if (w_lock) begin
        w_state_nxt = S_LOCKED;
        if (w_hold) begin
          w_burst_cnt_nxt = r_burst_cnt + CW'(1);
        end else begin
          w_owner_nxt     = w_gnt_id;
          w_burst_cnt_nxt = CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_burst_cnt <= '0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_last      <= w_last_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_rvalid0   <= w_gnt0 & ~r0_we;
      r_rvalid1   <= w_gnt1 & ~r1_we;
      if (w_gnt0 && !r0_we) r_rdata0 <= mem_rdata;
      if (w_gnt1 && !r1_we) r_rdata1 <= mem_rdata;
    end
  end

  assign r0_gnt    = w_gnt0;
  assign r1_gnt    = w_gnt1;
  assign mem_write = w_gnt_any & w_we;
  assign mem_addr  = w_gnt0 ? r0_addr  : (w_gnt1 ? r1_addr  : '0);
  assign mem_wdata = w_gnt0 ? r0_wdata : (w_gnt1 ? r1_wdata : '0);

  // A read granted just before reset must not report valid data during reset.
  assign r0_rvalid = r_rvalid0 & ~reset;
  assign r1_rvalid = r_rvalid1 & ~reset;
  assign r0_rdata  = r_rdata0;
  assign r1_rdata  = r_rdata1;

endmodule
